// File: rtl/aes_key_sched_ctrl_if.sv
// Bundle of key-load handshake, round-key read port and flat round-key bus
// between the AES-128 key schedule controller and its cipher core.
interface aes_key_sched_ctrl_if #(
    parameter int RK_IDX_W = 4
);
    // Key handshake: a key transfers on a rising edge where key_valid && key_ready;
    // key_valid may be held high, Key is sampled only on that edge, nothing is queued.
    logic [127:0]          Key;
    logic                  key_valid;
    logic                  key_ready;
    logic                  ks_busy;
    logic                  ks_done;
    logic                  keys_valid;
    logic                  rk_rd_en;
    logic [RK_IDX_W-1:0]   rk_rd_idx;
    logic [127:0]          rk_rd_data;
    logic                  rk_rd_valid;
    logic                  rk_rd_err;
    logic [1407:0]         SwappedRoundKey;

    modport slave (
        input  Key, key_valid, rk_rd_en, rk_rd_idx,
        output key_ready, ks_busy, ks_done, keys_valid,
               rk_rd_data, rk_rd_valid, rk_rd_err, SwappedRoundKey
    );

    modport master (
        output Key, key_valid, rk_rd_en, rk_rd_idx,
        input  key_ready, ks_busy, ks_done, keys_valid,
               rk_rd_data, rk_rd_valid, rk_rd_err, SwappedRoundKey
    );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// Sequential AES-128 key expansion (one round key per clock) into an 11-entry bank.
// Optional macro KS_KEY_CACHE_EN: re-accepting the already expanded key skips expansion.
module aes_key_sched_ctrl #(
    parameter int RK_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_key_sched_ctrl_if.slave  bus,
    output logic [1:0]           o_dbg_state
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXPAND = 2'd1, ST_DONE = 2'd2} state_t;

    localparam logic [RK_IDX_W-1:0] LAST_RND = RK_IDX_W'(10);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [127:0]   r_bank [0:10];
    logic [3:0]     r_rnd;
    logic [7:0]     r_rcon;
    logic           r_keys_valid;
    logic [127:0]   r_rd_data;
    logic           r_rd_valid;
    logic           r_rd_err;

    logic           w_accept, w_cache_hit, w_rd_ok;
    logic           w_key_ready, w_ks_busy, w_ks_done;
    logic [127:0]   w_prev, w_next, w_rd_mux;
    logic [31:0]    w_rot, w_sub, w_t, w_n0, w_n1, w_n2, w_n3;
    logic [1407:0]  w_srk;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (x^254) followed by the AES affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    assign w_accept = (r_state == ST_IDLE) && bus.key_valid;
`ifdef KS_KEY_CACHE_EN
    assign w_cache_hit = r_keys_valid && (bus.Key == r_bank[0]);
`else
    assign w_cache_hit = 1'b0;
`endif

    // One round of the key schedule from bank[rnd-1].
    always_comb begin
        w_prev = '0;
        for (int i = 0; i < 10; i++) begin
            if (r_rnd == 4'(i + 1)) w_prev = r_bank[i];
        end
        w_rot = {w_prev[23:0], w_prev[31:24]};
        w_sub = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])};
        w_t   = w_sub ^ {r_rcon, 24'h0};
        w_n0  = w_prev[127:96] ^ w_t;
        w_n1  = w_prev[95:64]  ^ w_n0;
        w_n2  = w_prev[63:32]  ^ w_n1;
        w_n3  = w_prev[31:0]   ^ w_n2;
        w_next = {w_n0, w_n1, w_n2, w_n3};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_key_ready = 1'b0;
        w_ks_busy   = 1'b0;
        w_ks_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_key_ready = 1'b1;
                if (w_accept) w_state_nxt = w_cache_hit ? ST_DONE : ST_EXPAND;
            end
            ST_EXPAND: begin
                w_ks_busy = 1'b1;
                if (r_rnd == 4'd10) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_ks_done   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 11; i++) r_bank[i] <= '0;
            r_rnd        <= 4'd0;
            r_rcon       <= 8'h01;
            r_keys_valid <= 1'b0;
        end else if (w_accept && !w_cache_hit) begin
            r_bank[0]    <= bus.Key;
            r_rnd        <= 4'd1;
            r_rcon       <= 8'h01;
            r_keys_valid <= 1'b0;
        end else if (r_state == ST_EXPAND) begin
            for (int i = 1; i < 11; i++) begin
                if (r_rnd == 4'(i)) r_bank[i] <= w_next;
            end
            r_rcon <= xtime(r_rcon);
            r_rnd  <= r_rnd + 4'd1;
            if (r_rnd == 4'd10) r_keys_valid <= 1'b1;
        end
    end

    // Read port sees keys_valid as it was before any same-edge accept.
    assign w_rd_ok = r_keys_valid && (bus.rk_rd_idx <= LAST_RND);

    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < 11; i++) begin
            if (bus.rk_rd_idx == RK_IDX_W'(i)) w_rd_mux = r_bank[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
        end else begin
            r_rd_valid <= bus.rk_rd_en;
            r_rd_err   <= bus.rk_rd_en && !w_rd_ok;
            r_rd_data  <= (bus.rk_rd_en && w_rd_ok) ? w_rd_mux : '0;
        end
    end

    always_comb begin
        w_srk = '0;
        for (int r = 0; r < 11; r++) w_srk[r*128 +: 128] = r_bank[r];
    end

    assign bus.key_ready       = w_key_ready;
    assign bus.ks_busy         = w_ks_busy;
    assign bus.ks_done         = w_ks_done;
    assign bus.keys_valid      = r_keys_valid;
    assign bus.rk_rd_data      = r_rd_data;
    assign bus.rk_rd_valid     = r_rd_valid;
    assign bus.rk_rd_err       = r_rd_err;
    assign bus.SwappedRoundKey = w_srk;
    assign o_dbg_state         = r_state;
endmodule
